// File: rtl/sprite_pkg.sv
// Shared sprite definitions: RAM word field layout, screen size and the
// plotter FSM state encoding. Imported by the sprite loader and the plotter.
package sprite_pkg;

    // Sprite RAM word layout: {x[15:10], y[9:4], colour[3:1], stop[0]}
    localparam int X_MSB    = 15;
    localparam int X_W      = 6;
    localparam int Y_MSB    = 9;
    localparam int Y_W      = 6;
    localparam int COL_MSB  = 3;
    localparam int COL_W    = 3;
    localparam int STOP_BIT = 0;

    // Visible area of the VGA adapter
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    // Plotter FSM states
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        DRAW,
        DONE
    } plot_state_t;

endpackage

// File: rtl/sprite_word_unpack.sv
// Splits a sprite RAM word into its fields, offsets the coordinates by the
// latched origin and decides whether the pixel lands on screen.
// Build option: SPRITE_PLOTTER_TRANSPARENT_EN suppresses pixels whose colour
// equals TRANSPARENT_COLOUR.
module sprite_word_unpack
    import sprite_pkg::*;
#(
    parameter int         SCREEN_W           = DEF_SCREEN_W,
    parameter int         SCREEN_H           = DEF_SCREEN_H,
    parameter logic [2:0] TRANSPARENT_COLOUR = 3'b000
) (
    input  logic [15:0] ram_data,
    input  logic [7:0]  origin_x,
    input  logic [6:0]  origin_y,
    output logic [7:0]  px,
    output logic [6:0]  py,
    output logic [2:0]  colour,
    output logic        stop,
    output logic        visible
);

`ifdef SPRITE_PLOTTER_TRANSPARENT_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [8:0]     sx;
    logic [7:0]     sy;
    logic           in_bounds;
    logic           keyed;

    // Field split and offset; sums are kept wide so off-screen pixels are
    // compared before any truncation to the adapter's coordinate width.
    always_comb begin
        x         = ram_data[X_MSB -: X_W];
        y         = ram_data[Y_MSB -: Y_W];
        colour    = ram_data[COL_MSB -: COL_W];
        stop      = ram_data[STOP_BIT];
        sx        = {1'b0, origin_x} + {3'b000, x};
        sy        = {1'b0, origin_y} + {2'b00, y};
        in_bounds = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));
        keyed     = KEY_EN && (colour == TRANSPARENT_COLOUR);
        visible   = in_bounds && !keyed;
        px        = sx[7:0];
        py        = sy[6:0];
    end

endmodule

// File: rtl/sprite_plotter.sv
// Sprite plotter: after a start pulse walks the sprite RAM from address 0,
// waits out the RAM read latency for each word and emits one plot strobe per
// on-screen pixel to the 160x120 VGA adapter, until a word with stop=0 or the
// last RAM address. All outputs are registered.
// Build option: SPRITE_PLOTTER_TRANSPARENT_EN (see sprite_word_unpack).
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int         READ_LATENCY       = 2,
    parameter int         SPRITE_WORDS       = 1024,
    parameter int         SCREEN_W           = DEF_SCREEN_W,
    parameter int         SCREEN_H           = DEF_SCREEN_H,
    parameter logic [2:0] TRANSPARENT_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  origin_x,
    input  logic [6:0]  origin_y,
    output logic [9:0]  addr_read,
    input  logic [15:0] ram_data,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int                WAIT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LATENCY - 1);
    localparam logic [9:0]        LAST_ADDR = 10'(SPRITE_WORDS - 1);

    plot_state_t       state, state_nx;
    logic [9:0]        count_q, count_nx;
    logic [WAIT_W-1:0] wait_q, wait_nx;
    logic [7:0]        org_x_q, org_x_nx;
    logic [6:0]        org_y_q, org_y_nx;
    logic [9:0]        addr_nx;
    logic [7:0]        vga_x_nx;
    logic [6:0]        vga_y_nx;
    logic [2:0]        vga_colour_nx;
    logic              plot_nx, busy_nx, done_nx;

    logic [7:0]        px;
    logic [6:0]        py;
    logic [2:0]        pcol;
    logic              pstop, pvis;

    sprite_word_unpack #(
        .SCREEN_W          (SCREEN_W),
        .SCREEN_H          (SCREEN_H),
        .TRANSPARENT_COLOUR(TRANSPARENT_COLOUR)
    ) u_unpack (
        .ram_data(ram_data),
        .origin_x(org_x_q),
        .origin_y(org_y_q),
        .px      (px),
        .py      (py),
        .colour  (pcol),
        .stop    (pstop),
        .visible (pvis)
    );

    // State, counters, latched origin and all outputs register here.
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            count_q    <= '0;
            wait_q     <= '0;
            org_x_q    <= '0;
            org_y_q    <= '0;
            addr_read  <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            count_q    <= count_nx;
            wait_q     <= wait_nx;
            org_x_q    <= org_x_nx;
            org_y_q    <= org_y_nx;
            addr_read  <= addr_nx;
            vga_x      <= vga_x_nx;
            vga_y      <= vga_y_nx;
            vga_colour <= vga_colour_nx;
            plot       <= plot_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

    // Next-state and next-output logic; busy/done follow the next state so
    // they line up with the registered state.
    // NOTE: every signal gets a default first so no latch can be inferred.
    always_comb begin
        state_nx      = state;
        count_nx      = count_q;
        wait_nx       = wait_q;
        org_x_nx      = org_x_q;
        org_y_nx      = org_y_q;
        addr_nx       = addr_read;
        vga_x_nx      = vga_x;
        vga_y_nx      = vga_y;
        vga_colour_nx = vga_colour;
        plot_nx       = 1'b0;

        unique case (state)
            IDLE: begin
                addr_nx = '0;
                if (start) begin
                    org_x_nx = origin_x;
                    org_y_nx = origin_y;
                    count_nx = '0;
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                addr_nx  = count_q;
                wait_nx  = WAIT_LOAD;
                state_nx = WAIT;
            end
            WAIT: begin
                if (wait_q == '0) begin
                    state_nx = DRAW;
                end else begin
                    wait_nx = wait_q - WAIT_W'(1);
                end
            end
            DRAW: begin
                vga_x_nx      = px;
                vga_y_nx      = py;
                vga_colour_nx = pcol;
                plot_nx       = pvis;
                // The RAM is never read past its last address
                if (!pstop || (count_q == LAST_ADDR)) begin
                    state_nx = DONE;
                end else begin
                    count_nx = count_q + 10'd1;
                    state_nx = ADDR;
                end
            end
            DONE: begin
                addr_nx  = '0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed testbench for sprite_plotter with a two-cycle-latency RAM model.
`timescale 1ns/1ps
module tb_sprite_plotter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  origin_x;
    logic [6:0]  origin_y;
    logic [9:0]  addr_read;
    logic [15:0] ram_data;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;
    logic        busy;
    logic        done;

    logic [15:0] mem [1024];
    logic [15:0] rd_pipe;

    int total = 0;
    int bad   = 0;

    int q_cyc[$];
    int q_x[$];
    int q_y[$];
    int q_c[$];
    int q_addr[$];
    int done_cyc;
    int max_addr;
    int idle_hits;

    sprite_plotter dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .origin_x  (origin_x),
        .origin_y  (origin_y),
        .addr_read (addr_read),
        .ram_data  (ram_data),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Sprite RAM read port: data valid two cycles after the address
    always @(posedge clk) begin
        rd_pipe  <= mem[addr_read];
        ram_data <= rd_pipe;
    end

    function automatic logic [15:0] w(input int x, input int y, input int c, input int s);
        return {6'(x), 6'(y), 3'(c), 1'(s)};
    endfunction

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] ox, input logic [6:0] oy);
        origin_x = ox;
        origin_y = oy;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Runs up to budget cycles after the start edge, logging every plot;
    // cycle c is the state just after the c-th edge following the start edge.
    task automatic run_sprite(input int budget, input int repulse_at,
                              input logic [7:0] rx, input logic [6:0] ry);
        q_cyc.delete();
        q_x.delete();
        q_y.delete();
        q_c.delete();
        q_addr.delete();
        done_cyc = -1;
        max_addr = 0;
        for (int c = 1; c <= budget; c++) begin
            if (c == repulse_at) begin
                start    = 1'b1;
                origin_x = rx;
                origin_y = ry;
            end else begin
                start = 1'b0;
            end
            tick();
            if (plot) begin
                q_cyc.push_back(c);
                q_x.push_back(int'(vga_x));
                q_y.push_back(int'(vga_y));
                q_c.push_back(int'(vga_colour));
                q_addr.push_back(int'(addr_read));
            end
            if (int'(addr_read) > max_addr) max_addr = int'(addr_read);
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        origin_x = '0;
        origin_y = '0;
        for (int i = 0; i < 1024; i++) mem[i] = w(0, 0, 1, 1);

        // Reset state
        #12;
        check("reset_outputs", 32'({addr_read, vga_x, vga_y, vga_colour, plot, busy, done}), 0);
        #1 resetn = 1'b1;
        tick();
        check("after_release_idle", 32'({addr_read, plot, busy, done}), 0);

        // Three-pixel sprite at origin (10,20)
        mem[0] = w(0, 0, 3'b100, 1);
        mem[1] = w(1, 0, 3'b010, 1);
        mem[2] = w(1, 1, 3'b001, 0);
        pulse_start(8'd10, 7'd20);
        check("t1_busy_after_start", 32'(busy), 1);
        check("t1_addr_after_start", 32'(addr_read), 0);
        run_sprite(100, 0, 8'd0, 7'd0);
        check("t1_plot_count", q_cyc.size(), 3);
        check("t1_p0_cycle", at(q_cyc, 0), 4);
        check("t1_p0_x", at(q_x, 0), 10);
        check("t1_p0_y", at(q_y, 0), 20);
        check("t1_p0_col", at(q_c, 0), 4);
        check("t1_p1_cycle", at(q_cyc, 1), 8);
        check("t1_p1_x", at(q_x, 1), 11);
        check("t1_p1_y", at(q_y, 1), 20);
        check("t1_p1_col", at(q_c, 1), 2);
        check("t1_p2_cycle", at(q_cyc, 2), 12);
        check("t1_p2_x", at(q_x, 2), 11);
        check("t1_p2_y", at(q_y, 2), 21);
        check("t1_p2_col", at(q_c, 2), 1);
        check("t1_done_cycle", done_cyc, 12);
        check("t1_max_addr", max_addr, 2);
        check("t1_busy_with_done", 32'(busy), 1);
        tick();
        check("t1_after_done", 32'({addr_read, plot, busy, done}), 0);

        // Clip at the bottom-right corner
        mem[0] = w(1, 1, 3'b111, 1);
        mem[1] = w(2, 0, 3'b111, 0);
        pulse_start(8'd158, 7'd118);
        run_sprite(100, 0, 8'd0, 7'd0);
        check("t2_plot_count", q_cyc.size(), 1);
        check("t2_p0_x", at(q_x, 0), 159);
        check("t2_p0_y", at(q_y, 0), 119);
        check("t2_p0_cycle", at(q_cyc, 0), 4);
        check("t2_done_cycle", done_cyc, 8);
        check("t2_clipped_x", 32'(vga_x), 160);
        check("t2_clipped_y", 32'(vga_y), 118);
        tick();

        // Sum beyond 8 bits must clip, not wrap on screen
        mem[0] = w(10, 0, 3'b001, 0);
        pulse_start(8'd250, 7'd0);
        run_sprite(100, 0, 8'd0, 7'd0);
        check("t2b_plot_count", q_cyc.size(), 0);
        check("t2b_low_x", 32'(vga_x), 4);
        check("t2b_done_cycle", done_cyc, 4);
        tick();

        // Black pixel followed by the final word
        mem[0] = w(0, 0, 3'b000, 1);
        mem[1] = w(3, 4, 3'b101, 0);
        pulse_start(8'd5, 7'd6);
        run_sprite(100, 0, 8'd0, 7'd0);
`ifdef SPRITE_PLOTTER_TRANSPARENT_EN
        check("t3_plot_count", q_cyc.size(), 1);
        check("t3_p0_x", at(q_x, 0), 8);
        check("t3_p0_y", at(q_y, 0), 10);
        check("t3_p0_cycle", at(q_cyc, 0), 8);
`else
        check("t3_plot_count", q_cyc.size(), 2);
        check("t3_p0_x", at(q_x, 0), 5);
        check("t3_p0_y", at(q_y, 0), 6);
        check("t3_p0_col", at(q_c, 0), 0);
        check("t3_p1_x", at(q_x, 1), 8);
        check("t3_p1_col", at(q_c, 1), 5);
`endif
        check("t3_done_cycle", done_cyc, 8);
        tick();

        // Start re-pulsed with another origin while busy is ignored
        mem[0] = w(0, 0, 3'b100, 1);
        mem[1] = w(1, 0, 3'b010, 1);
        mem[2] = w(1, 1, 3'b001, 0);
        pulse_start(8'd10, 7'd20);
        run_sprite(100, 2, 8'd50, 7'd50);
        check("t5_plot_count", q_cyc.size(), 3);
        check("t5_p0_x", at(q_x, 0), 10);
        check("t5_p0_y", at(q_y, 0), 20);
        check("t5_p2_x", at(q_x, 2), 11);
        check("t5_p2_y", at(q_y, 2), 21);
        check("t5_done_cycle", done_cyc, 12);
        tick();
        check("t5_idle_after", 32'(busy), 0);

        // No stop word anywhere: exactly 1024 pixels, then done
        for (int i = 0; i < 1024; i++) mem[i] = w(0, 0, 1, 1);
        pulse_start(8'd0, 7'd0);
        run_sprite(5000, 0, 8'd0, 7'd0);
        check("t4_plot_count", q_cyc.size(), 1024);
        check("t4_first_addr", at(q_addr, 0), 0);
        check("t4_last_addr", at(q_addr, 1023), 1023);
        check("t4_max_addr", max_addr, 1023);
        check("t4_done_cycle", done_cyc, 4096);
        tick();
        check("t4_idle_after", 32'({addr_read, busy, done}), 0);

        // Reset during the wait of word 5
        pulse_start(8'd3, 7'd4);
        repeat (21) tick();
        check("t6_addr_in_wait", 32'(addr_read), 5);
        check("t6_busy_in_wait", 32'(busy), 1);
        check("t6_vga_x_before", 32'(vga_x), 3);
        #2 resetn = 1'b0;
        #1;
        check("t6_async_reset", 32'({addr_read, vga_x, vga_y, vga_colour, plot, busy, done}), 0);
        tick();
        #3 resetn = 1'b1;
        idle_hits = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy || plot) idle_hits++;
        end
        check("t6_quiet_after_reset", idle_hits, 0);
        mem[0] = w(2, 2, 3'b011, 0);
        pulse_start(8'd0, 7'd0);
        run_sprite(100, 0, 8'd0, 7'd0);
        check("t6_restart_count", q_cyc.size(), 1);
        check("t6_restart_addr", at(q_addr, 0), 0);
        check("t6_restart_x", at(q_x, 0), 2);
        check("t6_restart_cycle", at(q_cyc, 0), 4);
        check("t6_restart_done", done_cyc, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
